rr_arb_mux_4: RTL and testbench

RR_ARB_MUX_4 -- requirements
Module: rr_arb_mux_4

---
 rtl/rr_arb_mux_4.sv | 101 ++++++++++
 tb/tb_rr_arb_mux_4.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux_4.sv
// Four-way round-robin arbiter feeding a single-entry output register.
// A grant is issued whenever the register is empty or draining this cycle.
module rr_arb_mux_4 #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [3:0]    i_req,
    input  logic [DW-1:0] i_din1,
    input  logic [DW-1:0] i_din2,
    input  logic [DW-1:0] i_din3,
    input  logic [DW-1:0] i_din4,
    input  logic          i_ready,
    output logic [3:0]    o_gnt,
    output logic [1:0]    o_sel,
    output logic          o_valid,
    output logic [DW-1:0] o_q
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic [DW-1:0] data_q, data_d;

    logic [DW-1:0] din [4];
    logic          slot_free;
    logic          win_found;
    logic [1:0]    win_idx;
    logic [1:0]    scan_idx;
    logic [3:0]    gnt;

    assign din[0] = i_din1;
    assign din[1] = i_din2;
    assign din[2] = i_din3;
    assign din[3] = i_din4;

    // A full register with i_ready high drains and refills in the same cycle.
    assign slot_free = (state_q == EMPTY) || i_ready;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        scan_idx  = 2'd0;
        for (int off = 0; off < 4; off++) begin
            scan_idx = ptr_q + off[1:0];
            if (!win_found && i_req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (slot_free && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    // Grant is suppressed combinationally while reset is held.
    assign o_gnt = i_rst_n ? gnt : 4'b0000;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        if (gnt != 4'b0000) begin
            state_d = FULL;
            ptr_d   = win_idx + 2'd1;
            sel_d   = win_idx;
            data_d  = din[win_idx];
        end else if (state_q == FULL && i_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = (state_q == FULL);
    assign o_sel   = sel_q;
    assign o_q     = data_q;

endmodule

// File: tb/tb_rr_arb_mux_4.sv
// Directed bench for rr_arb_mux_4: rotation, hold, drain, wrap and reset cases.
module tb_rr_arb_mux_4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [7:0] i_din1, i_din2, i_din3, i_din4;
    logic       i_ready;
    logic [3:0] o_gnt;
    logic [1:0] o_sel;
    logic       o_valid;
    logic [7:0] o_q;

    int n_vec = 0;
    int n_err = 0;

    rr_arb_mux_4 #(.DW(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_din1  (i_din1),
        .i_din2  (i_din2),
        .i_din3  (i_din3),
        .i_din4  (i_din4),
        .i_ready (i_ready),
        .o_gnt   (o_gnt),
        .o_sel   (o_sel),
        .o_valid (o_valid),
        .o_q     (o_q)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] sel, input logic [7:0] q,
                           input logic vld);
        chk({tag, "_sel"}, {30'd0, o_sel}, {30'd0, sel});
        chk({tag, "_q"}, {24'd0, o_q}, {24'd0, q});
        chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, vld});
    endtask

    logic [3:0] rot_gnt [5];
    logic [1:0] rot_sel [5];
    logic [7:0] rot_q   [5];

    initial begin
        rot_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rot_q   = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};

        i_rst_n = 1'b0;
        i_req   = 4'b0000;
        i_ready = 1'b0;
        i_din1  = 8'h10;
        i_din2  = 8'h20;
        i_din3  = 8'h30;
        i_din4  = 8'h40;

        // Reset state, including no grant while requests are present.
        #12;
        i_req = 4'b1111;
        #1;
        chk_out("rst", 2'd0, 8'h00, 1'b0);
        chk("rst_gnt", {28'd0, o_gnt}, 32'h0);
        tick();
        chk("rst_gnt_edge", {28'd0, o_gnt}, 32'h0);
        chk("rst_valid_edge", {31'd0, o_valid}, 32'h0);

        // Full rotation starting at requester 0.
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            $display("step rot%0d gnt=%b sel=%0d q=%h", k, o_gnt, o_sel, o_q);
            chk($sformatf("rot%0d_gnt", k), {28'd0, o_gnt}, {28'd0, rot_gnt[k]});
            tick();
            chk_out($sformatf("rot%0d", k), rot_sel[k], rot_q[k], 1'b1);
        end

        // Drain with no requests: valid drops, data and index hold.
        i_req = 4'b0000;
        #1;
        chk("drain_gnt", {28'd0, o_gnt}, 32'h0);
        tick();
        chk_out("drain", 2'd0, 8'h10, 1'b0);

        // Fill with 8'h11 while i_ready is low (ignored when empty), ptr -> 1.
        i_din1  = 8'h11;
        i_req   = 4'b0001;
        i_ready = 1'b0;
        #1;
        chk("fill_gnt", {28'd0, o_gnt}, 32'h1);
        tick();
        chk_out("fill", 2'd0, 8'h11, 1'b1);

        // Backpressure: five stalled cycles, no grant, output stable.
        i_req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_gnt", k), {28'd0, o_gnt}, 32'h0);
            tick();
            chk_out($sformatf("stall%0d", k), 2'd0, 8'h11, 1'b1);
        end
        i_ready = 1'b1;
        #1;
        chk("unstall_gnt", {28'd0, o_gnt}, 32'h2);
        tick();
        chk_out("unstall", 2'd1, 8'h20, 1'b1);

        // Grant requester 3 (ptr 2), then ptr wraps to 0.
        i_req = 4'b1000;
        #1;
        chk("r3_gnt", {28'd0, o_gnt}, 32'h8);
        tick();
        chk_out("r3", 2'd3, 8'h40, 1'b1);
        i_req = 4'b1001;
        #1;
        chk("wrap_gnt", {28'd0, o_gnt}, 32'h1);
        tick();
        chk_out("wrap", 2'd0, 8'h11, 1'b1);

        // Single persistent requester 2 is granted every cycle.
        i_req  = 4'b0100;
        i_din3 = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("solo%0d_gnt", k), {28'd0, o_gnt}, 32'h4);
            tick();
            chk_out($sformatf("solo%0d", k), 2'd2, 8'hA5, 1'b1);
        end

        // Bring ptr to 2 in FULL, then reset mid-stream.
        i_req = 4'b0010;
        #1;
        chk("pre_rst_gnt", {28'd0, o_gnt}, 32'h2);
        tick();
        chk_out("pre_rst", 2'd1, 8'h20, 1'b1);
        i_req   = 4'b1111;
        i_ready = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 2'd0, 8'h00, 1'b0);
        chk("mid_rst_gnt", {28'd0, o_gnt}, 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        #1;
        chk("post_rst_gnt", {28'd0, o_gnt}, 32'h1);
        tick();
        chk_out("post_rst", 2'd0, 8'h11, 1'b1);
        chk("post_rst_gnt2", {28'd0, o_gnt}, 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
